clock_divider_ctrl: RTL
=======================

Name: clock_divider_ctrl

Overview:
Sequencing and configuration controller for `clock_divider`. It owns the divider's `enable_i` and divide-ratio inputs. It runs a fixed warm-up delay before enabling the divider. It only changes the ratio or disables the divider while the divided clock is low, so no runt pulses reach downstream logic. Software and top-level control drive it through a valid/ready configuration port and start/stop strobes.

Parameters:
- DIV_W, 8, width of the divide-ratio field.
- RESET_DIV, 2, divide ratio loaded at reset; must be >= 2.
- WARMUP_CYCLES, 16, clk_i cycles spent in WARMUP before `div_en_o` asserts; must be >= 1.
- DRAIN_TIMEOUT, 255, maximum cycles to wait for `clk_out_i` low in DRAIN before forcing disable.

Ports:
- clk_i  input  1  system clock; the single clock domain, also the divider's source clock.
- rstn_i  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  single-cycle strobe: begin the enable sequence.
- stop_i  input  1  single-cycle strobe: stop the divider cleanly.
- cfg_valid_i  input  1  new divide ratio offered.
- cfg_div_i  input  DIV_W  requested divide ratio.
- cfg_ready_o  output  1  controller can accept a ratio this cycle.
- clk_out_i  input  1  divided clock fed back from the divider's `clk_out_o`; synchronous to clk_i.
- div_en_o  output  1  drives the divider's `enable_i`.
- div_ratio_o  output  DIV_W  ratio driven to the divider.
- busy_o  output  1  high in WARMUP and DRAIN.
- locked_o  output  1  divider running at `div_ratio_o`.
- cfg_err_o  output  1  one-cycle pulse when an accepted ratio is < 2.

Behaviour:
- Reset (async, rstn_i=0) puts the block in IDLE and sets:
  - div_en_o=0, div_ratio_o=RESET_DIV, locked_o=0, busy_o=0, cfg_err_o=0, cfg_ready_o=0;
  - warm-up counter=0, pending-ratio flag=0, registered clk_out_i copy=0.
- Reset has priority in every state. Reset mid-WARMUP or mid-DRAIN discards all pending state.
- All outputs are registered. No combinational path from any input to any output.
- cfg_ready_o=1 only in IDLE, or in RUN with no pending ratio. A handshake completes on the cycle where cfg_valid_i & cfg_ready_o are both 1.
- Any accepted cfg_div_i < 2 is dropped; cfg_err_o pulses high the next cycle; ratio and state are unchanged.
- FSM states: IDLE, WARMUP, RUN, DRAIN.
- IDLE:
  - div_en_o=0.
  - An accepted valid ratio loads div_ratio_o on the next cycle.
  - start_i -> WARMUP and clears the counter.
  - start_i and stop_i in the same cycle: stop wins, stay in IDLE.
- WARMUP:
  - Counter increments each cycle.
  - When the counter reaches WARMUP_CYCLES-1 -> RUN; div_en_o=1 from the first RUN cycle. Total delay from start_i to div_en_o high is WARMUP_CYCLES+1 cycles.
  - stop_i -> IDLE immediately; div_en_o never asserts.
  - start_i is ignored.
- RUN:
  - div_en_o=1.
  - locked_o sets on the first rising edge of clk_out_i (registered copy 0, current 1) and stays 1 until leaving RUN.
  - An accepted valid ratio is stored as pending -> DRAIN.
  - stop_i -> DRAIN.
  - Both stop_i and an accepted ratio in the same cycle: ratio stored as pending and stop recorded -> DRAIN.
  - start_i is ignored.
- DRAIN:
  - locked_o=0; div_en_o stays 1.
  - When clk_out_i is sampled 0, or the drain counter reaches DRAIN_TIMEOUT, div_en_o clears on the next cycle.
  - On that same cycle: if a ratio is pending, div_ratio_o loads it and the pending flag clears.
  - Next state is WARMUP if a ratio was pending and no stop was recorded; otherwise IDLE.
  - stop_i received during DRAIN is recorded and forces IDLE as the next state.
  - cfg_ready_o=0 throughout DRAIN.
- Counters saturate; they never wrap. The warm-up counter is $clog2(WARMUP_CYCLES+1) bits; the drain counter is $clog2(DRAIN_TIMEOUT+1) bits.
- div_ratio_o changes only while div_en_o=0.

Test Plan:
- Reset then start_i with WARMUP_CYCLES=16 -> div_en_o rises exactly 17 cycles after the start_i cycle; locked_o rises 1 cycle after the first clk_out_i rising edge; div_ratio_o=2.
- In IDLE, cfg_div_i=5 with valid -> cfg_ready_o=1, div_ratio_o=5 next cycle; then start_i -> RUN with ratio 5.
- In RUN with clk_out_i held high 10 cycles, cfg_div_i=8 accepted -> DRAIN, div_en_o stays 1 until clk_out_i=0. div_en_o drops the next cycle with div_ratio_o=8, then WARMUP and RUN again.
- In RUN with clk_out_i stuck at 1, stop_i -> div_en_o drops at the DRAIN_TIMEOUT+1 cycle; state IDLE; locked_o=0.
- cfg_div_i=1 accepted in IDLE -> cfg_err_o one-cycle pulse; div_ratio_o unchanged at 2.
- Assert rstn_i=0 for 1 cycle mid-WARMUP -> all outputs return to reset values asynchronously; a later start_i repeats the full 17-cycle warm-up.

Source files
------------

// File: rtl/clock_divider_ctrl.sv
// Sequencing/configuration controller for clock_divider: warm-up before enable,
// glitch-free ratio changes and disables (only while the divided clock is low).
module clock_divider_ctrl #(
    parameter int unsigned DIV_W         = 8,
    parameter int unsigned RESET_DIV     = 2,
    parameter int unsigned WARMUP_CYCLES = 16,
    parameter int unsigned DRAIN_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cfg_valid_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    input  logic             clk_out_i,
    output logic             div_en_o,
    output logic [DIV_W-1:0] div_ratio_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             cfg_err_o
);

    localparam int unsigned WCNT_W = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned DCNT_W = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
    logic               pend_q, pend_d;
    logic [DIV_W-1:0]   pend_ratio_q, pend_ratio_d;
    logic               stop_rec_q, stop_rec_d;
    logic               clk_out_q;
    logic               div_en_q, div_en_d;
    logic [DIV_W-1:0]   ratio_q, ratio_d;
    logic               busy_q, busy_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    logic               accept;
    logic               cfg_bad;
    logic               cfg_ok;
    logic               drain_done;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        dcnt_d       = dcnt_q;
        pend_d       = pend_q;
        pend_ratio_d = pend_ratio_q;
        stop_rec_d   = stop_rec_q;
        ratio_d      = ratio_q;

        accept     = cfg_valid_i & ready_q;
        cfg_bad    = cfg_div_i < DIV_W'(2);
        cfg_ok     = accept & ~cfg_bad;
        err_d      = accept & cfg_bad;
        drain_done = ~clk_out_i | (dcnt_q == DCNT_W'(DRAIN_TIMEOUT));

        case (state_q)
            S_IDLE: begin
                if (cfg_ok) begin
                    ratio_d = cfg_div_i;
                end
                if (start_i && !stop_i) begin
                    state_d = S_WARMUP;
                    wcnt_d  = '0;
                end
            end
            S_WARMUP: begin
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WCNT_W'(WARMUP_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else if (wcnt_q < WCNT_W'(WARMUP_CYCLES)) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_RUN: begin
                if (cfg_ok) begin
                    pend_d       = 1'b1;
                    pend_ratio_d = cfg_div_i;
                end
                if (cfg_ok || stop_i) begin
                    state_d    = S_DRAIN;
                    dcnt_d     = '0;
                    stop_rec_d = stop_i;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    // Disable and ratio update land on the same edge, so the
                    // divider never sees a new ratio while enabled.
                    if (pend_q) begin
                        ratio_d = pend_ratio_q;
                        pend_d  = 1'b0;
                    end
                    state_d    = (pend_q && !stop_rec_q && !stop_i) ? S_WARMUP : S_IDLE;
                    wcnt_d     = '0;
                    stop_rec_d = 1'b0;
                end else begin
                    if (stop_i) begin
                        stop_rec_d = 1'b1;
                    end
                    if (dcnt_q < DCNT_W'(DRAIN_TIMEOUT)) begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        div_en_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d   = (state_d == S_WARMUP) || (state_d == S_DRAIN);
        ready_d  = (state_d == S_IDLE) || ((state_d == S_RUN) && !pend_d);
        locked_d = (state_q == S_RUN) && (state_d == S_RUN) &&
                   (locked_q || (!clk_out_q && clk_out_i));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            dcnt_q       <= '0;
            pend_q       <= 1'b0;
            pend_ratio_q <= '0;
            stop_rec_q   <= 1'b0;
            clk_out_q    <= 1'b0;
            div_en_q     <= 1'b0;
            ratio_q      <= DIV_W'(RESET_DIV);
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            dcnt_q       <= dcnt_d;
            pend_q       <= pend_d;
            pend_ratio_q <= pend_ratio_d;
            stop_rec_q   <= stop_rec_d;
            clk_out_q    <= clk_out_i;
            div_en_q     <= div_en_d;
            ratio_q      <= ratio_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign div_en_o    = div_en_q;
    assign div_ratio_o = ratio_q;
    assign busy_o      = busy_q;
    assign locked_o    = locked_q;
    assign cfg_err_o   = err_q;

endmodule
